// File: rtl/cpu_dbg_ctrl.sv
// Debug run-control for the single-cycle CPU: synchronised debug requests drive
// a halt/step/run/break state machine that produces CPU and DMEM clock enables,
// plus instruction/data-address override muxes and a write-protected DMEM peek.
module cpu_dbg_ctrl #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16,
  parameter int NUM_BP      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step_req,
  input  logic                   run_req,
  input  logic                   halt_req,
  input  logic                   peek_req,
  input  logic [CNT_W-1:0]       run_count,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*XLEN-1:0] bp_addr,
  input  logic [XLEN-1:0]        pc,
  input  logic                   idata_ovr_en,
  input  logic [XLEN-1:0]        idata_ovr,
  input  logic [XLEN-1:0]        idata_mem,
  output logic [XLEN-1:0]        idata_cpu,
  input  logic                   daddr_ovr_en,
  input  logic [XLEN-1:0]        daddr_ovr,
  input  logic [XLEN-1:0]        daddr_cpu,
  output logic [XLEN-1:0]        daddr_mem,
  input  logic [3:0]             we_cpu,
  output logic [3:0]             we_mem,
  output logic                   cpu_en,
  output logic                   dmem_en,
  output logic [1:0]             state,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [CNT_W-1:0]       cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_STEP  = 2'b01,
    ST_RUN   = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  // Bit positions of the four requests inside the synchroniser vectors
  localparam int REQ_STEP = 0;
  localparam int REQ_RUN  = 1;
  localparam int REQ_HALT = 2;
  localparam int REQ_PEEK = 3;

  state_t                            cur_state;
  state_t                            nxt_state;
  logic   [CNT_W-1:0]                remaining;
  logic   [CNT_W-1:0]                nxt_remaining;
  logic                              skip_bp;
  logic                              nxt_skip_bp;
  logic   [NUM_BP-1:0]               nxt_bp_hit;
  logic   [NUM_BP-1:0]               bp_vec;
  logic                              bp_match;
  logic   [3:0]                      req_raw;
  logic   [3:0]                      req_rise;
  logic   [3:0]                      edge_q;
  logic   [SYNC_STAGES-1:0][3:0]     sync_q;
  logic                              peek_pulse;

  assign req_raw = {peek_req, halt_req, run_req, step_req};

  // Synchronise all four request levels, then keep one extra stage for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_raw};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign req_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Per-comparator PC breakpoint match
  always_comb begin
    bp_vec = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_vec[i] = bp_en[i] & (pc == bp_addr[i*XLEN +: XLEN]);
    end
  end

  assign bp_match = |bp_vec;

  // Next-state, run counter, breakpoint bookkeeping and enables for the run-control FSM
  always_comb begin
    nxt_state     = cur_state;
    nxt_remaining = remaining;
    nxt_skip_bp   = skip_bp;
    nxt_bp_hit    = bp_hit;
    cpu_en        = 1'b0;
    peek_pulse    = 1'b0;
    case (cur_state)
      ST_HALT, ST_BREAK: begin
        peek_pulse = req_rise[REQ_PEEK];
        if (req_rise[REQ_STEP]) begin
          nxt_state = ST_STEP;
        end else if (req_rise[REQ_RUN]) begin
          nxt_state     = ST_RUN;
          nxt_remaining = run_count;
          nxt_skip_bp   = 1'b1;
        end
      end
      ST_STEP: begin
        cpu_en    = 1'b1;
        nxt_state = ST_HALT;
      end
      ST_RUN: begin
        nxt_skip_bp = 1'b0;
        if (bp_match && !skip_bp) begin
          nxt_state  = ST_BREAK;
          nxt_bp_hit = bp_vec;
        end else if (req_rise[REQ_HALT]) begin
          nxt_state = ST_HALT;
        end else begin
          cpu_en = 1'b1;
          if ((run_count != '0) && (remaining == CNT_W'(1))) begin
            nxt_state     = ST_HALT;
            nxt_remaining = '0;
          end else if (remaining != '0) begin
            nxt_remaining = remaining - CNT_W'(1);
          end
        end
      end
      default: begin
        nxt_state = ST_HALT;
      end
    endcase
  end

  // Run-control state register, remaining count, breakpoint record and enabled-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= ST_HALT;
      remaining <= '0;
      skip_bp   <= 1'b0;
      bp_hit    <= '0;
      cycle_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      remaining <= nxt_remaining;
      skip_bp   <= nxt_skip_bp;
      bp_hit    <= nxt_bp_hit;
      if (cpu_en) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

  assign state     = cur_state;
  assign dmem_en   = cpu_en | peek_pulse;
  assign we_mem    = cpu_en ? we_cpu : 4'b0000;
  assign idata_cpu = idata_ovr_en ? idata_ovr : idata_mem;
  assign daddr_mem = daddr_ovr_en ? daddr_ovr : daddr_cpu;

endmodule
